// File: rtl/alu_iter_shifter_if.sv
// Request/response handshake bundle for the iterative shifter.
// Master issues operands and accepts results; slave is the shifter.
interface alu_iter_shifter_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_oper;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;

  modport master (
    output in_valid, in_data, in_shamt, in_oper, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_oper, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/alu_iter_shifter.sv
// Iterative 32-bit shifter: ROR/SLL/SRA/SRL, one power-of-two stage per clock.
// Optional ALU_ITER_SHIFTER_EARLY_DONE_EN skips stages above the top set bit.
module alu_iter_shifter (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  alu_iter_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] work_q, work_d;
  logic [4:0]  amt_q, amt_d;
  logic [1:0]  oper_q, oper_d;
  logic [4:0]  sh;
  logic [31:0] stage;
  logic        last;

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_data  = work_q;

  assign sh = 5'd1 << cnt_q;

  always_comb begin
    stage = work_q;
    unique case (oper_q)
      2'b00: stage = (work_q >> sh) |
                     (work_q << (6'd32 - {1'b0, sh}));
      2'b01: stage = work_q << sh;
      2'b10: stage = 32'($signed(work_q) >>> sh);
      2'b11: stage = work_q >> sh;
    endcase
  end

`ifdef ALU_ITER_SHIFTER_EARLY_DONE_EN
  logic [4:0] amt_hi;
  assign amt_hi = amt_q >> (cnt_q + 3'd1);
  // Stop once no higher shift-amount bit remains.
  assign last = (cnt_q == 3'd4) || (amt_hi == 5'd0);
`else
  assign last = (cnt_q == 3'd4);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    amt_d   = amt_q;
    oper_d  = oper_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            work_d  = bus.in_data;
            amt_d   = bus.in_shamt;
            oper_d  = bus.in_oper;
            cnt_d   = 3'd0;
            state_d = SHIFT;
`ifdef ALU_ITER_SHIFTER_EARLY_DONE_EN
            if (bus.in_shamt == 5'd0) state_d = DONE;
`endif
          end
        end
        SHIFT: begin
          if (amt_q[cnt_q]) work_d = stage;
          if (last) begin
            cnt_d   = 3'd0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      work_q  <= 32'd0;
      amt_q   <= 5'd0;
      oper_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      amt_q   <= amt_d;
      oper_q  <= oper_d;
    end
  end

endmodule

// File: tb/tb_alu_iter_shifter.sv
// Scoreboard bench for alu_iter_shifter: directed vectors, queued
// expectations, and a negedge monitor checking data, latency and spacing.
module tb_alu_iter_shifter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  alu_iter_shifter_if bus ();

  alu_iter_shifter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   start_q[$];
  int   checks = 0;
  int   errors = 0;
  int   mcyc = 0;
  bit   seen = 0;
  bit   b2b = 0;
  int   last_acc = -1;

  function automatic int exp_lat(input logic [4:0] s);
`ifdef ALU_ITER_SHIFTER_EARLY_DONE_EN
    int h;
    h = -1;
    for (int i = 0; i < 5; i++) if (s[i]) h = i;
    return (h < 0) ? 1 : h + 2;
`else
    return 6;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, req);
    end
  endtask

  // Monitor: latency from handshake cycle to first out_valid cycle.
  always @(negedge clk) begin
    mcyc++;
    if (!rst_n) begin
      start_q.delete();
      seen = 0;
    end else begin
      if (flush) begin
        start_q.delete();
        seen = 0;
      end else if (bus.in_valid && bus.in_ready) begin
        start_q.push_back(mcyc);
        if (b2b && last_acc >= 0)
          chk("accept_spacing", 32'(mcyc - last_acc), 32'd7);
        last_acc = mcyc;
      end
      if (bus.out_valid && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out got %h want none", bus.out_data);
        end else begin
          chk("out_data", bus.out_data, exp_q[0].d);
          if (!seen) begin
            seen = 1;
            if (start_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL latency got no_start want %0d", exp_q[0].lat);
            end else begin
              chk("latency", 32'(mcyc - start_q[0]), 32'(exp_q[0].lat));
            end
          end
          if (bus.out_ready) begin
            void'(exp_q.pop_front());
            if (start_q.size() > 0) void'(start_q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [31:0] d, input logic [4:0] s,
                       input logic [1:0] o, input bit track,
                       input logic [31:0] e);
    int n;
    bit hs;
    if (track) exp_q.push_back('{d: e, lat: exp_lat(s)});
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shamt = s;
    bus.in_oper  = o;
    hs = 0;
    n = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = bus.in_ready && !flush && rst_n;
      @(posedge clk); #1;
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom;
    bus.in_shamt = 5'($urandom);
    bus.in_oper  = 2'($urandom);
    if (!hs) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got none want handshake");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_data   = 32'd0;
    bus.in_shamt  = 5'd0;
    bus.in_oper   = 2'b00;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Rotate with output stalled for three cycles.
    bus.out_ready = 1'b0;
    issue(32'h12345678, 5'd8, 2'b00, 1, 32'h78123456);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    issue(32'h80000000, 5'd31, 2'b10, 1, 32'hFFFFFFFF);
    drain();
    issue(32'hF0000000, 5'd4, 2'b11, 1, 32'h0F000000);
    drain();
    issue(32'h00000001, 5'd31, 2'b01, 1, 32'h80000000);
    drain();
    issue(32'h00000001, 5'd1, 2'b00, 1, 32'h80000000);
    drain();
    issue(32'h0000FFFF, 5'd16, 2'b01, 1, 32'hFFFF0000);
    drain();
    issue(32'h7FFF0000, 5'd4, 2'b10, 1, 32'h07FFF000);
    drain();
    issue(32'h80000001, 5'd31, 2'b00, 1, 32'h00000003);
    drain();

    // Flush in C3 of a request.
    issue(32'hDEADBEEF, 5'd7, 2'b01, 0, 32'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    issue(32'hA5A5A5A5, 5'd0, 2'b11, 1, 32'hA5A5A5A5);
    drain();

    // Reset during SHIFT.
    issue(32'hCAFEF00D, 5'd3, 2'b11, 0, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_out_data", bus.out_data, 32'd0);
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Back-to-back with out_ready high.
    b2b = 1;
    last_acc = -1;
    issue(32'h00000010, 5'd4, 2'b11, 1, 32'h00000001);
    issue(32'h00000003, 5'd2, 2'b01, 1, 32'h0000000C);
    issue(32'h000000F0, 5'd4, 2'b00, 1, 32'h0000000F);
    drain();
    b2b = 0;

    repeat (10) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
